// File: rtl/cluster_pkg.sv
// cluster_pkg: shared definitions for the cluster unpacker slice.
//   MXPADS    - default number of pads in the reconstructed hit map
//   MXADRBITS - width of a cluster's first-pad address
//   MXCNTBITS - width of a cluster's size-minus-one field
//   cluster_t - one cluster word {adr, cnt}
//   state_t   - unpacker FSM states
package cluster_pkg;

    localparam int MXPADS    = 768;
    localparam int MXADRBITS = 11;
    localparam int MXCNTBITS = 3;

    typedef struct packed {
        logic [MXADRBITS-1:0] adr;
        logic [MXCNTBITS-1:0] cnt;
    } cluster_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_t;

endpackage

// File: rtl/cluster_mask_gen.sv
// cluster_mask_gen: combinational expansion of one cluster into a pad mask.
//   cl   (in)  cluster word {adr, cnt}
//   mask (out) one bit per pad, set for every pad covered by the cluster
// Build option CLUSTER_UNPACKER_SIZE_EXPAND_EN: when defined the cluster
// covers pads adr..adr+cnt; otherwise only pad adr and cnt is ignored.
// Pads beyond MXPADS-1 simply fall off the mask (no wrap), and an address
// at or above MXPADS yields an all-zero mask.
module cluster_mask_gen import cluster_pkg::*; #(
    parameter int MXPADS = cluster_pkg::MXPADS
) (
    input  cluster_t          cl,
    output logic [MXPADS-1:0] mask
);

`ifdef CLUSTER_UNPACKER_SIZE_EXPAND_EN
    always_comb begin
        int unsigned lo;
        int unsigned hi;
        lo   = 32'(cl.adr);
        hi   = lo + 32'(cl.cnt);
        mask = '0;
        for (int unsigned i = 0; i < MXPADS; i++) begin
            mask[i] = (i >= lo) && (i <= hi);
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt = ^cl.cnt;

    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < MXPADS; i++) begin
            mask[i] = (i == 32'(cl.adr));
        end
    end
`endif

endmodule

// File: rtl/cluster_unpacker.sv
// cluster_unpacker: rebuilds a pad hit map from a stream of cluster words.
//   clock        (in)  rising-edge clock
//   reset_n      (in)  asynchronous active-low reset
//   clst_valid   (in)  cluster word presented
//   clst_ready   (out) cluster accepted this cycle when valid is also high
//   clst_adr     (in)  first pad of the cluster
//   clst_cnt     (in)  cluster size minus one
//   clst_last    (in)  final cluster of the frame
//   vpfs_out     (out) reconstructed hit map, held between frame_valid pulses
//   frame_valid  (out) one-cycle pulse when vpfs_out holds a new frame
//   err_adr      (out) sticky: a cluster had an address >= MXPADS
//   err_ovf      (out) sticky: a frame had more than MXCLUSTERS clusters
// Build option CLUSTER_UNPACKER_SIZE_EXPAND_EN selects multi-pad clusters
// (see cluster_mask_gen).
module cluster_unpacker import cluster_pkg::*; #(
    parameter int MXPADS     = cluster_pkg::MXPADS,
    parameter int MXCLUSTERS = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 clst_valid,
    output logic                 clst_ready,
    input  logic [MXADRBITS-1:0] clst_adr,
    input  logic [MXCNTBITS-1:0] clst_cnt,
    input  logic                 clst_last,
    output logic [MXPADS-1:0]    vpfs_out,
    output logic                 frame_valid,
    output logic                 err_adr,
    output logic                 err_ovf
);

    localparam int CNTW = $clog2(MXCLUSTERS + 1);

    state_t            state_q, state_d;
    logic              ready_q;
    logic [MXPADS-1:0] acc_q;
    logic [MXPADS-1:0] frame_buf_q;
    logic [MXPADS-1:0] vpfs_q;
    logic              emit_q;
    logic              fv_q;
    logic [CNTW-1:0]   ncl_q;
    logic              err_adr_q, err_ovf_q;

    logic [MXPADS-1:0] mask;
    logic              accept, adr_bad, ovf, take;

    cluster_mask_gen #(
        .MXPADS (MXPADS)
    ) u_mask_gen (
        .cl   ('{adr: clst_adr, cnt: clst_cnt}),
        .mask (mask)
    );

    assign accept  = clst_valid && clst_ready;
    assign adr_bad = 32'(clst_adr) >= 32'(MXPADS);
    assign ovf     = ncl_q >= CNTW'(MXCLUSTERS);
    assign take    = accept && !adr_bad && !ovf;

    always_comb begin
        state_d    = state_q;
        clst_ready = 1'b0;
        case (state_q)
            ACCUM: begin
                clst_ready = ready_q;
                if (accept && clst_last) state_d = EMIT;
            end
            EMIT:    state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    // The accumulator is cleared in EMIT so the next frame can start one
    // cycle later; frame_buf_q holds the finished frame for one more edge so
    // vpfs_out and frame_valid change together, two edges after the last
    // cluster is accepted.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ACCUM;
            ready_q     <= 1'b0;
            acc_q       <= '0;
            frame_buf_q <= '0;
            vpfs_q      <= '0;
            emit_q      <= 1'b0;
            fv_q        <= 1'b0;
            ncl_q       <= '0;
            err_adr_q   <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            state_q <= state_d;
            emit_q  <= (state_q == EMIT);
            fv_q    <= emit_q;
            if (emit_q) vpfs_q <= frame_buf_q;

            if (state_q == EMIT) begin
                frame_buf_q <= acc_q;
                acc_q       <= '0;
                ncl_q       <= '0;
            end else if (accept) begin
                if (take) acc_q <= acc_q | mask;
                if (!ovf) ncl_q <= ncl_q + CNTW'(1);
            end

            if (accept && adr_bad) err_adr_q <= 1'b1;
            if (accept && ovf)     err_ovf_q <= 1'b1;
        end
    end

    assign vpfs_out    = vpfs_q;
    assign frame_valid = fv_q;
    assign err_adr     = err_adr_q;
    assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_cluster_unpacker.sv
module tb_cluster_unpacker;

    localparam int NP = 768;
`ifdef CLUSTER_UNPACKER_SIZE_EXPAND_EN
    localparam bit EXPAND = 1'b1;
`else
    localparam bit EXPAND = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          clst_valid = 1'b0;
    logic          clst_ready;
    logic [10:0]   clst_adr = '0;
    logic [2:0]    clst_cnt = '0;
    logic          clst_last = 1'b0;
    logic [NP-1:0] vpfs_out;
    logic          frame_valid;
    logic          err_adr;
    logic          err_ovf;

    int checks = 0;
    int fails  = 0;
    logic [NP-1:0] exp;

    always #5 clock = ~clock;

    cluster_unpacker #(
        .MXPADS     (NP),
        .MXCLUSTERS (8)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .clst_valid  (clst_valid),
        .clst_ready  (clst_ready),
        .clst_adr    (clst_adr),
        .clst_cnt    (clst_cnt),
        .clst_last   (clst_last),
        .vpfs_out    (vpfs_out),
        .frame_valid (frame_valid),
        .err_adr     (err_adr),
        .err_ovf     (err_ovf)
    );

    // Presents one word and returns #1 after the edge that accepts it.
    task automatic send(input logic [10:0] adr, input logic [2:0] cnt, input logic last);
        int unsigned n;
        clst_valid = 1'b1;
        clst_adr   = adr;
        clst_cnt   = cnt;
        clst_last  = last;
        n = 0;
        @(negedge clock);
        while (!clst_ready && n < 20) begin
            n++;
            @(negedge clock);
        end
        checks++;
        if (clst_ready !== 1'b1) begin
            fails++;
            $display("FAIL send_ready_timeout: adr %0d ready %b want 1", adr, clst_ready);
        end
        @(posedge clock); #1;
        clst_valid = 1'b0;
        clst_last  = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (clst_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", clst_ready); end
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL rst_fv: got %b want 0", frame_valid); end
        checks++; if (vpfs_out !== '0) begin fails++; $display("FAIL rst_vpfs: got %h want 0", vpfs_out); end
        checks++; if ({err_adr, err_ovf} !== 2'b00) begin fails++; $display("FAIL rst_err: got %b want 00", {err_adr, err_ovf}); end
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checks++; if (clst_ready !== 1'b0) begin fails++; $display("FAIL rst_ready_pre_edge: got %b want 0", clst_ready); end
        @(posedge clock); #1;
        checks++; if (clst_ready !== 1'b1) begin fails++; $display("FAIL rst_ready_first_edge: got %b want 1", clst_ready); end
    endtask

    task automatic test_single;
        send(11'd10, 3'd2, 1'b1);
        exp = '0;
        exp[10] = 1'b1;
        if (EXPAND) begin exp[11] = 1'b1; exp[12] = 1'b1; end
        checks++; if (clst_ready !== 1'b0) begin fails++; $display("FAIL single_ready_emit: got %b want 0", clst_ready); end
        @(posedge clock); #1;
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL single_fv_edge1: got %b want 0", frame_valid); end
        @(posedge clock); #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL single_fv_edge2: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL single_vpfs: got %h want %h", vpfs_out, exp); end
        @(posedge clock); #1;
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL single_fv_pulse: got %b want 0", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL single_vpfs_hold: got %h want %h", vpfs_out, exp); end
    endtask

    task automatic test_merge;
        send(11'd5, 3'd3, 1'b0);
        send(11'd7, 3'd3, 1'b1);
        exp = '0;
        if (EXPAND) begin
            for (int i = 5; i <= 10; i++) exp[i] = 1'b1;
        end else begin
            exp[5] = 1'b1; exp[7] = 1'b1;
        end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL merge_fv: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL merge_vpfs: got %h want %h", vpfs_out, exp); end
    endtask

    task automatic test_clip;
        send(11'd766, 3'd7, 1'b1);
        exp = '0;
        exp[766] = 1'b1;
        if (EXPAND) exp[767] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL clip_fv: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL clip_vpfs: got %h want %h", vpfs_out, exp); end
        checks++; if (err_adr !== 1'b0) begin fails++; $display("FAIL clip_err_adr: got %b want 0", err_adr); end
    endtask

    task automatic test_back_to_back;
        send(11'd20, 3'd0, 1'b1);
        send(11'd30, 3'd0, 1'b1);
        exp = '0;
        exp[20] = 1'b1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL b2b_fv_a: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL b2b_vpfs_a: got %h want %h", vpfs_out, exp); end
        @(posedge clock); #1;
        checks++; if (frame_valid !== 1'b0) begin fails++; $display("FAIL b2b_fv_gap: got %b want 0", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL b2b_vpfs_hold: got %h want %h", vpfs_out, exp); end
        @(posedge clock); #1;
        exp = '0;
        exp[30] = 1'b1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL b2b_fv_b: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL b2b_vpfs_b: got %h want %h", vpfs_out, exp); end
    endtask

    task automatic test_bad_adr;
        send(11'd800, 3'd0, 1'b1);
        checks++; if (err_adr !== 1'b1) begin fails++; $display("FAIL badadr_err: got %b want 1", err_adr); end
        repeat (2) @(posedge clock);
        #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL badadr_fv: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== '0) begin fails++; $display("FAIL badadr_vpfs: got %h want 0", vpfs_out); end
    endtask

    task automatic test_overflow;
        for (int k = 0; k < 8; k++) send(11'(k * 10), 3'd0, 1'b0);
        checks++; if (err_ovf !== 1'b0) begin fails++; $display("FAIL ovf_err_early: got %b want 0", err_ovf); end
        send(11'd80, 3'd0, 1'b1);
        checks++; if (err_ovf !== 1'b1) begin fails++; $display("FAIL ovf_err: got %b want 1", err_ovf); end
        exp = '0;
        for (int k = 0; k < 8; k++) exp[k * 10] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL ovf_fv: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL ovf_vpfs: got %h want %h", vpfs_out, exp); end
        checks++; if (err_adr !== 1'b1) begin fails++; $display("FAIL ovf_err_adr_sticky: got %b want 1", err_adr); end
    endtask

    task automatic test_reset_mid;
        int fv_seen;
        send(11'd100, 3'd0, 1'b0);
        send(11'd200, 3'd0, 1'b0);
        send(11'd300, 3'd0, 1'b0);
        reset_n = 1'b0;
        fv_seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (frame_valid !== 1'b0) fv_seen++;
        end
        checks++; if (clst_ready !== 1'b0) begin fails++; $display("FAIL rmid_ready: got %b want 0", clst_ready); end
        checks++; if ({err_adr, err_ovf} !== 2'b00) begin fails++; $display("FAIL rmid_err_clear: got %b want 00", {err_adr, err_ovf}); end
        checks++; if (vpfs_out !== '0) begin fails++; $display("FAIL rmid_vpfs: got %h want 0", vpfs_out); end
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (frame_valid !== 1'b0) fv_seen++;
        end
        checks++; if (fv_seen !== 0) begin fails++; $display("FAIL rmid_no_fv: got %0d pulses want 0", fv_seen); end
        send(11'd50, 3'd0, 1'b1);
        exp = '0;
        exp[50] = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (frame_valid !== 1'b1) begin fails++; $display("FAIL rmid_fv: got %b want 1", frame_valid); end
        checks++; if (vpfs_out !== exp) begin fails++; $display("FAIL rmid_vpfs_next: got %h want %h", vpfs_out, exp); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_merge();
        test_clip();
        test_back_to_back();
        test_bad_adr();
        test_overflow();
        test_reset_mid();
        repeat (2) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
